io_responder: RTL and testbench

- Memory-mapped IO target that sits on the core's IO port (IO_mem_addr / IO_mem_wdata / IO_mem_wr / IO_mem_rdata) and answers its IO loads and stores.
- Provides an LED register, a UART transmitter fed by a TX FIFO, and a status/control register.
- Read data is returned combinationally in the same cycle as the address, because the core samples IO_mem_rdata at the end of its memory stage.

---
 rtl/io_responder.sv | 328 ++++++++++++++++++++++++++++++++
 tb/tb_io_responder.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/io_responder.sv
// io_responder: memory-mapped IO target for the core's IO port.
//
// It answers IO loads and stores with an LED register, a UART transmitter fed
// by a TX FIFO, and a status/control register. Read data is combinational so
// the core can sample it in the same cycle it presents the address.
//
// Optional build macro: IO_UART_RX_EN adds an 8N1 receiver on uart_rx
// (register idx4 RXDATA and STATUS bits[6:4]). Without it, idx4 and
// STATUS[6:4] read 0 and uart_rx is ignored.
//
// Register map (index = IO_mem_addr[4:2]; other address bits ignored):
//   0 LEDS      R/W  leds <= wdata[LED_W-1:0]
//   1 UART_DATA W    push wdata[7:0] into the TX FIFO; reads 0
//   2 STATUS    R    [0] tx_busy [1] full [2] empty [3] overflow
//                    [4] rx_valid [5] rx_overrun [6] frame_err [15:8] count
//               W    wdata[3] clears overflow, [5] rx_overrun, [6] frame_err
//   3 DIVISOR   R    constant DIV
//   4 RXDATA    R    {valid, byte}; any write clears valid (RX build only)
//
// Ports:
//   clk           clock
//   resetn        synchronous, active-low reset
//   IO_mem_addr   byte address from the core
//   IO_mem_wdata  store data, full word, unshifted
//   IO_mem_wr     one-cycle write strobe, already qualified with IO space
//   IO_mem_rdata  combinational read data
//   leds          LED register
//   uart_tx       registered serial out, 8N1, idle high
//   uart_rx       serial in (RX build only)

`default_nettype none

module io_responder #(
  parameter int CLK_FREQ_HZ = 50000000,
  parameter int BAUD        = 115200,
  parameter int FIFO_DEPTH  = 16,
  parameter int LED_W       = 5
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [31:0]      IO_mem_addr,
  input  logic [31:0]      IO_mem_wdata,
  input  logic             IO_mem_wr,
  output logic [31:0]      IO_mem_rdata,
  output logic [LED_W-1:0] leds,
  output logic             uart_tx,
  input  logic             uart_rx
);

  localparam int DIV = CLK_FREQ_HZ / BAUD;
  localparam int TW  = $clog2(DIV);
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int CW  = AW + 1;
  localparam logic [TW-1:0] BIT_RELOAD = TW'(DIV - 1);

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;

  // Address decode
  logic [2:0] idx;
  logic       led_we, push, stat_we;

  assign idx     = IO_mem_addr[4:2];
  assign led_we  = IO_mem_wr && (idx == 3'd0);
  assign push    = IO_mem_wr && (idx == 3'd1);
  assign stat_we = IO_mem_wr && (idx == 3'd2);

  // Bits of the bus that no register looks at.
  logic unused_bus;
  assign unused_bus = ^{IO_mem_addr[31:5], IO_mem_addr[1:0], IO_mem_wdata, uart_rx};

  // LED register
  always_ff @(posedge clk) begin
    if (!resetn)     leds <= '0;
    else if (led_we) leds <= IO_mem_wdata[LED_W-1:0];
  end

  // TX FIFO
  logic [7:0]    fifo_mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          full, empty, push_ok, pop, overflow;

  // Full is taken from the pre-edge count, so a push while full is dropped
  // even when the transmitter pops on the same edge.
  assign full    = (count == CW'(FIFO_DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push && !full;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop)     rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push_ok) - CW'(pop);
      if (push && full)                 overflow <= 1'b1;
      else if (stat_we && IO_mem_wdata[3]) overflow <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) fifo_mem[wr_ptr] <= IO_mem_wdata[7:0];
  end

  // TX FSM
  tx_state_t tx_state, tx_state_nxt;
  logic [TW-1:0] tx_tmr, tx_tmr_nxt;
  logic [2:0]    tx_bit, tx_bit_nxt;
  logic [7:0]    tx_sh, tx_sh_nxt;
  logic          tx_q, tx_nxt;

  assign uart_tx = tx_q;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      tx_state <= TX_IDLE;
      tx_tmr   <= '0;
      tx_bit   <= '0;
      tx_q     <= 1'b1;
    end else begin
      tx_state <= tx_state_nxt;
      tx_tmr   <= tx_tmr_nxt;
      tx_bit   <= tx_bit_nxt;
      tx_q     <= tx_nxt;
    end
  end

  always_ff @(posedge clk) begin
    tx_sh <= tx_sh_nxt;
  end

  // The shift register is shifted as each bit is launched, so tx_sh[0] is
  // always the next bit to put on the line.
  always_comb begin
    tx_state_nxt = tx_state;
    tx_tmr_nxt   = tx_tmr;
    tx_bit_nxt   = tx_bit;
    tx_sh_nxt    = tx_sh;
    tx_nxt       = tx_q;
    pop          = 1'b0;
    case (tx_state)
      TX_IDLE: begin
        if (!empty) begin
          pop          = 1'b1;
          tx_sh_nxt    = fifo_mem[rd_ptr];
          tx_nxt       = 1'b0;
          tx_tmr_nxt   = BIT_RELOAD;
          tx_state_nxt = TX_START;
        end
      end
      TX_START: begin
        if (tx_tmr == '0) begin
          tx_nxt       = tx_sh[0];
          tx_sh_nxt    = {1'b0, tx_sh[7:1]};
          tx_bit_nxt   = 3'd0;
          tx_tmr_nxt   = BIT_RELOAD;
          tx_state_nxt = TX_DATA;
        end else begin
          tx_tmr_nxt = tx_tmr - TW'(1);
        end
      end
      TX_DATA: begin
        if (tx_tmr == '0) begin
          tx_tmr_nxt = BIT_RELOAD;
          if (tx_bit == 3'd7) begin
            tx_nxt       = 1'b1;
            tx_state_nxt = TX_STOP;
          end else begin
            tx_nxt     = tx_sh[0];
            tx_sh_nxt  = {1'b0, tx_sh[7:1]};
            tx_bit_nxt = tx_bit + 3'd1;
          end
        end else begin
          tx_tmr_nxt = tx_tmr - TW'(1);
        end
      end
      TX_STOP: begin
        if (tx_tmr == '0) tx_state_nxt = TX_IDLE;
        else              tx_tmr_nxt   = tx_tmr - TW'(1);
      end
      default: tx_state_nxt = TX_IDLE;
    endcase
  end

  logic [2:0]  rx_status;
  logic [31:0] rx_word;

`ifdef IO_UART_RX_EN
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  logic rx_meta, rx_sync, rx_prev;
  rx_state_t rx_state, rx_state_nxt;
  logic [TW-1:0] rx_tmr, rx_tmr_nxt;
  logic [2:0]    rx_bit, rx_bit_nxt;
  logic [7:0]    rx_sh, rx_sh_nxt, rx_byte;
  logic          rx_done, rx_ferr;
  logic          rx_valid, rx_overrun, frame_err;
  logic          rxdata_we;

  assign rxdata_we = IO_mem_wr && (idx == 3'd4);

  // Two-flop synchroniser plus one delayed copy for falling-edge detect.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= uart_rx;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      rx_state <= RX_IDLE;
      rx_tmr   <= '0;
      rx_bit   <= '0;
    end else begin
      rx_state <= rx_state_nxt;
      rx_tmr   <= rx_tmr_nxt;
      rx_bit   <= rx_bit_nxt;
    end
  end

  always_ff @(posedge clk) begin
    rx_sh <= rx_sh_nxt;
    if (rx_done) rx_byte <= rx_sh;
  end

  // Start is checked half a bit after the falling edge; every later sample
  // lands one full bit period after the previous one, i.e. mid-bit.
  always_comb begin
    rx_state_nxt = rx_state;
    rx_tmr_nxt   = rx_tmr;
    rx_bit_nxt   = rx_bit;
    rx_sh_nxt    = rx_sh;
    rx_done      = 1'b0;
    rx_ferr      = 1'b0;
    case (rx_state)
      RX_IDLE: begin
        if (rx_prev && !rx_sync) begin
          rx_tmr_nxt   = TW'(DIV / 2 - 1);
          rx_state_nxt = RX_START;
        end
      end
      RX_START: begin
        if (rx_tmr == '0) begin
          if (!rx_sync) begin
            rx_tmr_nxt   = BIT_RELOAD;
            rx_bit_nxt   = 3'd0;
            rx_state_nxt = RX_DATA;
          end else begin
            rx_state_nxt = RX_IDLE;
          end
        end else begin
          rx_tmr_nxt = rx_tmr - TW'(1);
        end
      end
      RX_DATA: begin
        if (rx_tmr == '0) begin
          rx_sh_nxt  = {rx_sync, rx_sh[7:1]};
          rx_tmr_nxt = BIT_RELOAD;
          if (rx_bit == 3'd7) rx_state_nxt = RX_STOP;
          else                rx_bit_nxt   = rx_bit + 3'd1;
        end else begin
          rx_tmr_nxt = rx_tmr - TW'(1);
        end
      end
      RX_STOP: begin
        if (rx_tmr == '0) begin
          if (rx_sync) rx_done = 1'b1;
          else         rx_ferr = 1'b1;
          rx_state_nxt = RX_IDLE;
        end else begin
          rx_tmr_nxt = rx_tmr - TW'(1);
        end
      end
      default: rx_state_nxt = RX_IDLE;
    endcase
  end

  // A completed byte wins over a same-cycle clear.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      rx_valid   <= 1'b0;
      rx_overrun <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      if (rx_done)        rx_valid <= 1'b1;
      else if (rxdata_we) rx_valid <= 1'b0;
      if (rx_done && rx_valid)             rx_overrun <= 1'b1;
      else if (stat_we && IO_mem_wdata[5]) rx_overrun <= 1'b0;
      if (rx_ferr)                         frame_err <= 1'b1;
      else if (stat_we && IO_mem_wdata[6]) frame_err <= 1'b0;
    end
  end

  assign rx_status = {frame_err, rx_overrun, rx_valid};
  assign rx_word   = {23'b0, rx_valid, rx_byte};
`else
  assign rx_status = 3'b000;
  assign rx_word   = 32'b0;
`endif

  // Combinational read mux; reads have no side effects.
  logic busy;
  assign busy = (tx_state != TX_IDLE);

  always_comb begin
    IO_mem_rdata = '0;
    case (idx)
      3'd0:    IO_mem_rdata = 32'(leds);
      3'd2:    IO_mem_rdata = (32'(count) << 8) |
                              {25'b0, rx_status, overflow, empty, full, busy};
      3'd3:    IO_mem_rdata = 32'(DIV);
      3'd4:    IO_mem_rdata = rx_word;
      default: IO_mem_rdata = '0;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_io_responder.sv
// Testbench for io_responder with DIV=10, FIFO_DEPTH=4, LED_W=5.
// Bytes accepted by the TX FIFO are queued as expected output; a background
// decoder reconstructs each uart_tx frame and compares it against the queue.
`timescale 1ns/1ps

module tb_io_responder;
  localparam int DIV = 10;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [31:0] IO_mem_addr = '0;
  logic [31:0] IO_mem_wdata = '0;
  logic        IO_mem_wr = 1'b0;
  logic [31:0] IO_mem_rdata;
  logic [4:0]  leds;
  logic        uart_tx;
  logic        uart_rx = 1'b1;

  int n_cmp = 0;
  int n_err = 0;
  logic [7:0] sb[$];

  always #5 clk = ~clk;

  io_responder #(
    .CLK_FREQ_HZ(1000000),
    .BAUD       (100000),
    .FIFO_DEPTH (4),
    .LED_W      (5)
  ) dut (
    .clk         (clk),
    .resetn      (resetn),
    .IO_mem_addr (IO_mem_addr),
    .IO_mem_wdata(IO_mem_wdata),
    .IO_mem_wr   (IO_mem_wr),
    .IO_mem_rdata(IO_mem_rdata),
    .leds        (leds),
    .uart_tx     (uart_tx),
    .uart_rx     (uart_rx)
  );

  task automatic io_write(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    IO_mem_addr  = a;
    IO_mem_wdata = d;
    IO_mem_wr    = 1'b1;
    @(negedge clk);
    IO_mem_wr    = 1'b0;
  endtask

  task automatic io_read(input logic [31:0] a, output logic [31:0] d);
    IO_mem_addr = a;
    #1;
    d = IO_mem_rdata;
  endtask

  // Frame decoder: samples mid-bit, pops the scoreboard on each stop bit.
  task automatic monitor();
    bit busy = 0;
    int cnt = 0;
    logic [9:0] bits = '0;
    logic [7:0] exp;
    forever begin
      @(negedge clk);
      #2;
      if (!resetn) busy = 0;
      else if (!busy) begin
        if (uart_tx === 1'b0) begin busy = 1; cnt = 0; end
      end else cnt++;
      if (busy && resetn) begin
        if (cnt % DIV == DIV / 2) bits[cnt / DIV] = uart_tx;
        if (cnt == 9 * DIV + DIV / 2) begin
          busy = 0;
          n_cmp++;
          if (sb.size() == 0) begin
            n_err++;
            $display("FAIL uart_frame: got unexpected byte %02h, required no frame", bits[8:1]);
          end else begin
            exp = sb.pop_front();
            if (bits[8:1] !== exp || bits[0] !== 1'b0 || bits[9] !== 1'b1) begin
              n_err++;
              $display("FAIL uart_frame: got %03h (stop,data,start) required byte %02h framed", bits, exp);
            end
          end
        end
      end
    end
  endtask

  task automatic test_reset();
    logic [31:0] d;
    resetn = 1'b0;
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    n_cmp++; if (leds !== 5'h00) begin n_err++; $display("FAIL reset_leds: got %h required 00", leds); end
    n_cmp++; if (uart_tx !== 1'b1) begin n_err++; $display("FAIL reset_tx: got %b required 1", uart_tx); end
    io_read(32'h8, d);
    n_cmp++; if (d !== 32'h4) begin n_err++; $display("FAIL reset_status: got %h required 00000004", d); end
    @(negedge clk);
    io_read(32'hC, d);
    n_cmp++; if (d !== 32'd10) begin n_err++; $display("FAIL divisor: got %h required 0000000a", d); end
    io_read(32'h4, d);
    n_cmp++; if (d !== 32'h0) begin n_err++; $display("FAIL uart_data_read: got %h required 0", d); end
    @(negedge clk);
    io_read(32'h14, d);
    n_cmp++; if (d !== 32'h0) begin n_err++; $display("FAIL unmapped_read: got %h required 0", d); end
`ifndef IO_UART_RX_EN
    io_read(32'h10, d);
    n_cmp++; if (d !== 32'h0) begin n_err++; $display("FAIL rxdata_absent: got %h required 0", d); end
`endif
  endtask

  task automatic test_leds();
    logic [31:0] d;
    io_write(32'h0, 32'h1F);
    n_cmp++; if (leds !== 5'h1F) begin n_err++; $display("FAIL leds_write: got %h required 1f", leds); end
    io_read(32'h0, d);
    n_cmp++; if (d !== 32'h1F) begin n_err++; $display("FAIL leds_read: got %h required 0000001f", d); end
    io_write(32'h0, 32'hFFFF_FFE0);
    n_cmp++; if (leds !== 5'h00) begin n_err++; $display("FAIL leds_trunc: got %h required 00", leds); end
    io_write(32'hFFFF_FFE0, 32'h0A);
    n_cmp++; if (leds !== 5'h0A) begin n_err++; $display("FAIL leds_hiaddr: got %h required 0a", leds); end
    io_write(32'h1C, 32'h1F);
    io_write(32'h14, 32'h1F);
    io_write(32'hC, 32'h1234);
    n_cmp++; if (leds !== 5'h0A) begin n_err++; $display("FAIL leds_unmapped: got %h required 0a", leds); end
    io_read(32'hC, d);
    n_cmp++; if (d !== 32'd10) begin n_err++; $display("FAIL divisor_ro: got %h required 0000000a", d); end
    io_read(32'h8, d);
    n_cmp++; if (d !== 32'h4) begin n_err++; $display("FAIL unmapped_no_push: got %h required 00000004", d); end
    @(negedge clk);
    resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    n_cmp++; if (leds !== 5'h00) begin n_err++; $display("FAIL leds_reset: got %h required 00", leds); end
  endtask

  task automatic test_frame();
    logic [31:0] d;
    logic [9:0]  fr;
    bit ok, busy_ok;
    fr = {1'b1, 8'h55, 1'b0};
    sb.push_back(8'h55);
    io_write(32'h4, 32'h55);
    n_cmp++; if (uart_tx !== 1'b1) begin n_err++; $display("FAIL tx_write_edge: got %b required 1", uart_tx); end
    io_read(32'h8, d);
    n_cmp++; if (d !== 32'h100) begin n_err++; $display("FAIL status_queued: got %h required 00000100", d); end
    @(negedge clk);
    busy_ok = 1;
    for (int b = 0; b < 10; b++) begin
      ok = 1;
      for (int c = 0; c < DIV; c++) begin
        if (uart_tx !== fr[b]) ok = 0;
        if (IO_mem_rdata[0] !== 1'b1) busy_ok = 0;
        @(negedge clk);
      end
      n_cmp++;
      if (!ok) begin n_err++; $display("FAIL frame_bit%0d: got a level other than required %b", b, fr[b]); end
    end
    n_cmp++; if (!busy_ok) begin n_err++; $display("FAIL busy_in_frame: got busy=0 required 1"); end
    io_read(32'h8, d);
    n_cmp++; if (d !== 32'h4) begin n_err++; $display("FAIL status_after_frame: got %h required 00000004", d); end
  endtask

  task automatic test_overflow();
    logic [31:0] d;
    logic [7:0]  burst [6];
    bit found;
    burst = '{8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'hE5, 8'hF6};
    sb.push_back(8'h11);
    io_write(32'h4, 32'h11);
    // Back-to-back pushes; the first coincides with the pop of 0x11.
    for (int i = 0; i < 6; i++) begin
      IO_mem_addr  = 32'h4;
      IO_mem_wdata = {24'b0, burst[i]};
      IO_mem_wr    = 1'b1;
      if (i < 4) sb.push_back(burst[i]);
      @(negedge clk);
    end
    IO_mem_wr = 1'b0;
    io_read(32'h8, d);
    n_cmp++; if (d !== 32'h40B) begin n_err++; $display("FAIL status_full_ovf: got %h required 0000040b", d); end
    io_write(32'h8, 32'h8);
    io_read(32'h8, d);
    n_cmp++; if (d !== 32'h403) begin n_err++; $display("FAIL ovf_clear: got %h required 00000403", d); end
    // Find the single idle cycle between frames, then push on the pop edge.
    found = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      io_read(32'h8, d);
      if (d[0] == 1'b0) begin found = 1; break; end
    end
    n_cmp++; if (!found) begin n_err++; $display("FAIL idle_gap: got no idle cycle required one within 200 cycles"); end
    IO_mem_addr  = 32'h4;
    IO_mem_wdata = 32'hEE;
    IO_mem_wr    = 1'b1;
    @(negedge clk);
    IO_mem_wr = 1'b0;
    io_read(32'h8, d);
    n_cmp++; if (d !== 32'h309) begin n_err++; $display("FAIL push_on_pop_full: got %h required 00000309", d); end
    found = 0;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      io_read(32'h8, d);
      if (d == 32'hC) begin found = 1; break; end
    end
    n_cmp++; if (!found) begin n_err++; $display("FAIL drain: got status %h required 0000000c within 600 cycles", d); end
    repeat (3) @(negedge clk);
    n_cmp++; if (sb.size() != 0) begin n_err++; $display("FAIL sb_empty: got %0d pending required 0", sb.size()); end
    io_write(32'h8, 32'h8);
    io_read(32'h8, d);
    n_cmp++; if (d !== 32'h4) begin n_err++; $display("FAIL ovf_clear2: got %h required 00000004", d); end
  endtask

  task automatic test_reset_mid_frame();
    logic [31:0] d;
    int lows;
    io_write(32'h4, 32'h5A);
    io_write(32'h4, 32'h3C);
    repeat (41) @(negedge clk);
    resetn = 1'b0;
    @(negedge clk);
    n_cmp++; if (uart_tx !== 1'b1) begin n_err++; $display("FAIL abort_tx: got %b required 1", uart_tx); end
    io_read(32'h8, d);
    n_cmp++; if (d !== 32'h4) begin n_err++; $display("FAIL abort_status: got %h required 00000004", d); end
    resetn = 1'b1;
    lows = 0;
    for (int i = 0; i < 150; i++) begin
      @(negedge clk);
      if (uart_tx !== 1'b1) lows++;
    end
    n_cmp++; if (lows != 0) begin n_err++; $display("FAIL no_frame_after_abort: got %0d low cycles required 0", lows); end
  endtask

`ifdef IO_UART_RX_EN
  task automatic send_rx(input logic [7:0] b, input logic stop);
    logic [9:0] fr;
    fr = {stop, b, 1'b0};
    for (int k = 0; k < 10; k++) begin
      uart_rx = fr[k];
      repeat (DIV) @(negedge clk);
    end
    uart_rx = 1'b1;
    repeat (DIV) @(negedge clk);
  endtask

  task automatic test_rx();
    logic [31:0] d;
    send_rx(8'hA3, 1'b1);
    io_read(32'h10, d);
    n_cmp++; if (d !== 32'h1A3) begin n_err++; $display("FAIL rx_byte: got %h required 000001a3", d); end
    io_write(32'h10, 32'h0);
    io_read(32'h10, d);
    n_cmp++; if (d !== 32'h0A3) begin n_err++; $display("FAIL rx_clear: got %h required 000000a3", d); end
    send_rx(8'h3C, 1'b0);
    io_read(32'h8, d);
    n_cmp++; if (d[6] !== 1'b1) begin n_err++; $display("FAIL rx_frame_err: got %b required 1", d[6]); end
    @(negedge clk);
    io_read(32'h10, d);
    n_cmp++; if (d[8] !== 1'b0) begin n_err++; $display("FAIL rx_err_valid: got %b required 0", d[8]); end
  endtask
`endif

  initial begin
    fork
      monitor();
    join_none
    test_reset();
    test_leds();
    test_frame();
    test_overflow();
    test_reset_mid_frame();
`ifdef IO_UART_RX_EN
    test_rx();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
